// File: rtl/float64_pkg.sv
// Shared widths, exception-flag encodings and arbiter state type for the
// double-precision round-and-pack datapath.
package float64_pkg;

    localparam int unsigned EXP_W  = 12;
    localparam int unsigned SIG_W  = 64;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned FLAG_W = 32;

    localparam logic [FLAG_W-1:0] FLAG_INEXACT   = 32'd1;
    localparam logic [FLAG_W-1:0] FLAG_UNDERFLOW = 32'd4;
    localparam logic [FLAG_W-1:0] FLAG_OVERFLOW  = 32'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } rp_arb_state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SIG_W-1:0] sig;
    } rp_operand_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or above ptr, wrapping to zero.
// Produces both one-hot and encoded grant.
module rr_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt_c,
    output logic [IDX_W-1:0] gnt_idx_c,
    output logic             gnt_any_c
);

    int unsigned      k;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_c     = '0;
        gnt_idx_c = '0;
        gnt_any_c = 1'b0;
        k         = 0;
        idx       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = 32'(ptr) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            idx = IDX_W'(k);
            if (!gnt_any_c && req[idx]) begin
                gnt_any_c  = 1'b1;
                gnt_c[idx] = 1'b1;
                gnt_idx_c  = idx;
            end
        end
    end

endmodule

// File: rtl/round_pack_arbiter.sv
// Serialises round-and-pack jobs from NREQ requesters onto one shared unit,
// routes each result back and keeps the sticky exception-flag register.
module round_pack_arbiter
    import float64_pkg::*;
#(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ-1:0]         req_sign,
    input  logic [EXP_W*NREQ-1:0]   req_exp,
    input  logic [SIG_W*NREQ-1:0]   req_sig,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [FLAG_W-1:0]       rsp_flags,
    output logic                    rp_start,
    input  logic                    rp_done,
    output logic                    rp_zSign,
    output logic [EXP_W-1:0]        rp_zExp,
    output logic [SIG_W-1:0]        rp_zSig,
    output logic [FLAG_W-1:0]       rp_flag_i,
    input  logic [FLAG_W-1:0]       rp_flag_o,
    input  logic                    rp_flag_vld,
    input  logic [DATA_W-1:0]       rp_return,
    input  logic                    flag_clr,
    output logic [FLAG_W-1:0]       float_exception_flag
);

    rp_arb_state_t     state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  gidx_q, gidx_d;
    rp_operand_t       op_q, op_d;
    logic [FLAG_W-1:0] op_flags_q, op_flags_d;
    logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
    logic [FLAG_W-1:0] sticky_q, sticky_d;
    logic              rp_start_q, rp_start_d;

    logic [NREQ-1:0]   gnt_c;
    logic [IDX_W-1:0]  gnt_idx_c;
    logic              gnt_any_c;
    logic              merge_c;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (ptr_q),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c),
        .gnt_any_c (gnt_any_c)
    );

    // Accept is offered only from IDLE, so req_ready never depends on rp_* inputs.
    assign req_ready = (state_q == IDLE && !ap_rst) ? gnt_c : '0;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        op_d        = op_q;
        op_flags_d  = op_flags_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rp_start_d  = rp_start_q;
        merge_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_any_c) begin
                    op_d.sign  = req_sign[gnt_idx_c];
                    op_d.exp   = req_exp[32'(gnt_idx_c)*EXP_W +: EXP_W];
                    op_d.sig   = req_sig[32'(gnt_idx_c)*SIG_W +: SIG_W];
                    gidx_d     = gnt_idx_c;
                    op_flags_d = '0;
                    ptr_d      = (gnt_idx_c == IDX_W'(NREQ-1)) ? '0 : gnt_idx_c + IDX_W'(1);
                    rp_start_d = 1'b1;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (rp_flag_vld) begin
                    op_flags_d = op_flags_q | rp_flag_o;
                end
                if (rp_done) begin
                    merge_c             = 1'b1;
                    rsp_data_d          = rp_return;
                    rsp_flags_d         = op_flags_d;
                    rsp_valid_d         = '0;
                    rsp_valid_d[gidx_q] = 1'b1;
                    rp_start_d          = 1'b0;
                    state_d             = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[gidx_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear hits the old value only; a job merging in the same cycle survives.
        sticky_d = (flag_clr ? '0 : sticky_q) | (merge_c ? op_flags_d : '0);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            op_q        <= '0;
            op_flags_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            sticky_q    <= '0;
            rp_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            op_q        <= op_d;
            op_flags_q  <= op_flags_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            sticky_q    <= sticky_d;
            rp_start_q  <= rp_start_d;
        end
    end

    assign rsp_valid            = rsp_valid_q;
    assign rsp_data             = rsp_data_q;
    assign rsp_flags            = rsp_flags_q;
    assign rp_start             = rp_start_q;
    assign rp_zSign             = op_q.sign;
    assign rp_zExp              = op_q.exp;
    assign rp_zSig              = op_q.sig;
    assign rp_flag_i            = '0;
    assign float_exception_flag = sticky_q;

endmodule

// File: tb/tb_round_pack_arbiter.sv
// Directed bench for round_pack_arbiter; the bench itself plays the
// round-and-pack unit with hand-computed results and flags.
module tb_round_pack_arbiter;

    localparam int unsigned NREQ = 2;

    logic              ap_clk = 1'b0;
    logic              ap_rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   req_sign = '0;
    logic [12*NREQ-1:0] req_exp = '0;
    logic [64*NREQ-1:0] req_sig = '0;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready = '0;
    logic [63:0]       rsp_data;
    logic [31:0]       rsp_flags;
    logic              rp_start;
    logic              rp_done = 1'b0;
    logic              rp_zSign;
    logic [11:0]       rp_zExp;
    logic [63:0]       rp_zSig;
    logic [31:0]       rp_flag_i;
    logic [31:0]       rp_flag_o = '0;
    logic              rp_flag_vld = 1'b0;
    logic [63:0]       rp_return = '0;
    logic              flag_clr = 1'b0;
    logic [31:0]       float_exception_flag;

    int n_checks = 0;
    int n_fail   = 0;

    round_pack_arbiter #(.NREQ(NREQ)) dut (
        .ap_clk               (ap_clk),
        .ap_rst               (ap_rst),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_sign             (req_sign),
        .req_exp              (req_exp),
        .req_sig              (req_sig),
        .rsp_valid            (rsp_valid),
        .rsp_ready            (rsp_ready),
        .rsp_data             (rsp_data),
        .rsp_flags            (rsp_flags),
        .rp_start             (rp_start),
        .rp_done              (rp_done),
        .rp_zSign             (rp_zSign),
        .rp_zExp              (rp_zExp),
        .rp_zSig              (rp_zSig),
        .rp_flag_i            (rp_flag_i),
        .rp_flag_o            (rp_flag_o),
        .rp_flag_vld          (rp_flag_vld),
        .rp_return            (rp_return),
        .flag_clr             (flag_clr),
        .float_exception_flag (float_exception_flag)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic s, input logic [11:0] e, input logic [63:0] m);
        req_sign[r]          = s;
        req_exp[12*r +: 12]  = e;
        req_sig[64*r +: 64]  = m;
    endtask

    // Expect requester r to be granted this cycle, then check the unit operands.
    task automatic accept(input int r, input logic s, input logic [11:0] e, input logic [63:0] m);
        #1;
        chk("req_ready_grant", 64'(req_ready), 64'(1) << r);
        tick();
        chk("rp_start_after_accept", 64'(rp_start), 64'(1));
        chk("rp_zSign", 64'(rp_zSign), 64'(s));
        chk("rp_zExp", 64'(rp_zExp), 64'(e));
        chk("rp_zSig", rp_zSig, m);
        chk("req_ready_busy", 64'(req_ready), 64'(0));
    endtask

    // Play the unit: latency L counting the first start cycle, optional early
    // flag pulse one cycle before done, flags with done, optional flag_clr at done.
    task automatic unit(input int lat, input logic [63:0] ret, input logic [31:0] early,
                        input logic [31:0] at_done, input logic clr);
        for (int i = 1; i < lat; i++) begin
            if (i == lat - 1 && early != 32'd0) begin
                rp_flag_o   = early;
                rp_flag_vld = 1'b1;
            end
            chk("rp_start_busy", 64'(rp_start), 64'(1));
            tick();
            rp_flag_o   = '0;
            rp_flag_vld = 1'b0;
        end
        rp_done   = 1'b1;
        rp_return = ret;
        if (at_done != 32'd0) begin
            rp_flag_o   = at_done;
            rp_flag_vld = 1'b1;
        end
        flag_clr = clr;
        tick();
        rp_done     = 1'b0;
        rp_return   = '0;
        rp_flag_o   = '0;
        rp_flag_vld = 1'b0;
        flag_clr    = 1'b0;
    endtask

    task automatic resp(input int r, input logic [63:0] data, input logic [31:0] flags,
                        input logic [31:0] sticky);
        chk("rsp_valid_route", 64'(rsp_valid), 64'(1) << r);
        chk("rsp_data", rsp_data, data);
        chk("rsp_flags", 64'(rsp_flags), 64'(flags));
        chk("sticky", 64'(float_exception_flag), 64'(sticky));
        chk("rp_start_dropped", 64'(rp_start), 64'(0));
        rsp_ready    = '0;
        rsp_ready[r] = 1'b1;
        tick();
        rsp_ready = '0;
        chk("rsp_valid_released", 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        tick();
        tick();
        chk("reset_rp_start", 64'(rp_start), 64'(0));
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        ap_rst = 1'b0;
        tick();
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        chk("reset_rsp_data", rsp_data, 64'(0));
        chk("reset_rsp_flags", 64'(rsp_flags), 64'(0));
        chk("reset_sticky", 64'(float_exception_flag), 64'(0));
        chk("rp_flag_i_tied", 64'(rp_flag_i), 64'(0));

        // Exact 1.0
        set_req(0, 1'b0, 12'h3FE, 64'h4000000000000000);
        req_valid = 2'b01;
        accept(0, 1'b0, 12'h3FE, 64'h4000000000000000);
        req_valid = '0;
        unit(2, 64'h3FF0000000000000, 32'd0, 32'd0, 1'b0);
        resp(0, 64'h3FF0000000000000, 32'd0, 32'd0);

        // Inexact
        set_req(0, 1'b0, 12'h3FE, 64'h4000000000000001);
        req_valid = 2'b01;
        accept(0, 1'b0, 12'h3FE, 64'h4000000000000001);
        req_valid = '0;
        unit(3, 64'h3FF0000000000000, 32'd0, 32'd1, 1'b0);
        resp(0, 64'h3FF0000000000000, 32'd1, 32'd1);

        // Overflow, flags split across two vld pulses
        set_req(0, 1'b1, 12'h7FE, 64'h4000000000000000);
        req_valid = 2'b01;
        accept(0, 1'b1, 12'h7FE, 64'h4000000000000000);
        req_valid = '0;
        unit(4, 64'hFFF0000000000000, 32'd8, 32'd1, 1'b0);
        resp(0, 64'hFFF0000000000000, 32'd9, 32'd9);

        // Stray done while idle must be ignored
        rp_done = 1'b1;
        tick();
        rp_done = 1'b0;
        tick();
        chk("idle_done_no_rsp", 64'(rsp_valid), 64'(0));
        chk("idle_done_no_start", 64'(rp_start), 64'(0));

        // Backpressure with clear coinciding with an inexact done
        set_req(1, 1'b0, 12'h3FE, 64'h4000000000000001);
        set_req(0, 1'b0, 12'h3FE, 64'h4000000000000000);
        req_valid = 2'b10;
        accept(1, 1'b0, 12'h3FE, 64'h4000000000000001);
        req_valid = 2'b11;
        unit(3, 64'h3FF0000000000000, 32'd0, 32'd1, 1'b1);
        chk("clr_with_merge", 64'(float_exception_flag), 64'(1));
        rsp_ready = 2'b01;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 64'(2'b10));
            chk("bp_rsp_data", rsp_data, 64'h3FF0000000000000);
            chk("bp_no_accept", 64'(req_ready), 64'(0));
            tick();
        end
        req_valid = '0;
        resp(1, 64'h3FF0000000000000, 32'd1, 32'd1);

        // Reset one cycle after accept
        set_req(0, 1'b0, 12'h3FE, 64'h4000000000000001);
        req_valid = 2'b01;
        accept(0, 1'b0, 12'h3FE, 64'h4000000000000001);
        req_valid = '0;
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        chk("rst_rp_start", 64'(rp_start), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_sticky", 64'(float_exception_flag), 64'(0));
        rp_done = 1'b1;
        rp_return = 64'h3FF0000000000000;
        tick();
        rp_done = 1'b0;
        rp_return = '0;
        tick();
        chk("rst_dropped_job", 64'(rsp_valid), 64'(0));

        // Fairness with both held; first grant 0 shows ptr was reset
        set_req(0, 1'b0, 12'h3FE, 64'h4000000000000000);
        set_req(1, 1'b1, 12'h3FE, 64'h4000000000000001);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                accept(0, 1'b0, 12'h3FE, 64'h4000000000000000);
                unit(2, 64'h3FF0000000000000, 32'd0, 32'd0, 1'b0);
                resp(0, 64'h3FF0000000000000, 32'd0, (k == 0) ? 32'd0 : 32'd1);
            end else begin
                accept(1, 1'b1, 12'h3FE, 64'h4000000000000001);
                unit(2, 64'hBFF0000000000000, 32'd0, 32'd1, 1'b0);
                resp(1, 64'hBFF0000000000000, 32'd1, 32'd1);
            end
        end
        req_valid = '0;

        // Clear alone
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("clr_alone", 64'(float_exception_flag), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
